// File: rtl/csm_arbiter.sv
// csm_arbiter: two-requester arbiter and lock manager for the critical-section register file.
// Owns the per-register lock table and serialises A/B requests onto one memory port.
`default_nettype none

module csm_arbiter #(
   parameter int DATABITS = 8,
   parameter int MEMSIZE  = 8,
   parameter int MEMBITS  = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1
) (
   input  logic                clk,
   input  logic                reset_n,

   input  logic                A_req,
   input  logic                A_rw,
   input  logic                A_hold,
   input  logic                A_release,
   input  logic [MEMBITS-1:0]  A_addr,
   input  logic [DATABITS-1:0] A_wdata,
   output logic                A_done,
   output logic [1:0]          A_err,
   output logic [DATABITS-1:0] A_rdata,
   output logic [MEMSIZE-1:0]  A_locks,

   input  logic                B_req,
   input  logic                B_rw,
   input  logic                B_hold,
   input  logic                B_release,
   input  logic [MEMBITS-1:0]  B_addr,
   input  logic [DATABITS-1:0] B_wdata,
   output logic                B_done,
   output logic [1:0]          B_err,
   output logic [DATABITS-1:0] B_rdata,
   output logic [MEMSIZE-1:0]  B_locks,

   output logic                mem_en,
   output logic                mem_we,
   output logic [MEMBITS-1:0]  mem_addr,
   output logic [DATABITS-1:0] mem_wdata,
   input  logic [DATABITS-1:0] mem_rdata
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_RDATA = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   localparam logic [1:0] E_NONE   = 2'b00;
   localparam logic [1:0] E_INUSE  = 2'b01;
   localparam logic [1:0] E_DWRITE = 2'b10;
   localparam logic [1:0] E_DHOLD  = 2'b11;

   logic [1:0] r_state;
   logic       r_last_b;     // 1 = B won the previous arbitration
   logic       r_win_b;      // side currently being serviced
   logic       r_lose_dn;    // loser of a same-cycle conflict completes with the winner
   logic [1:0] r_lose_err;

   logic                w_any;
   logic                w_win_b;
   logic                w_hold;
   logic                w_rel;
   logic                w_rw;
   logic [MEMBITS-1:0]  w_addr;
   logic [DATABITS-1:0] w_wdata;
   logic                w_own_a;
   logic                w_own_b;
   logic                w_inuse;
   logic                w_same;
   logic                w_a_wr;
   logic                w_b_wr;
   logic                w_dual_wr;
   logic                w_dual_hold;
   logic                w_dual;

   assign w_any   = A_req | B_req;
   assign w_win_b = B_req & (~A_req | ~r_last_b);

   assign w_hold  = w_win_b ? B_hold  : A_hold;
   assign w_rel   = (w_win_b ? B_release : A_release) & ~w_hold;
   assign w_rw    = w_win_b ? B_rw    : A_rw;
   assign w_addr  = w_win_b ? B_addr  : A_addr;
   assign w_wdata = w_win_b ? B_wdata : A_wdata;

   assign w_own_a = A_locks[w_addr];
   assign w_own_b = B_locks[w_addr];
   assign w_inuse = w_win_b ? w_own_a : w_own_b;

   assign w_same  = A_req & B_req & (A_addr == B_addr);
   assign w_a_wr  = A_rw & ~A_hold & ~A_release;
   assign w_b_wr  = B_rw & ~B_hold & ~B_release;

   // A dual write only collapses when the winner will actually reach memory
   assign w_dual_wr   = w_same & w_a_wr & w_b_wr & ~w_inuse;
   assign w_dual_hold = w_same & A_hold & B_hold & ~w_own_a & ~w_own_b;
   assign w_dual      = w_dual_wr | w_dual_hold;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_last_b   <= 1'b1;
         r_win_b    <= 1'b0;
         r_lose_dn  <= 1'b0;
         r_lose_err <= E_NONE;
         A_done     <= 1'b0;
         A_err      <= E_NONE;
         A_rdata    <= '0;
         A_locks    <= '0;
         B_done     <= 1'b0;
         B_err      <= E_NONE;
         B_rdata    <= '0;
         B_locks    <= '0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_last_b   <= w_win_b;
                  r_win_b    <= w_win_b;
                  r_lose_dn  <= w_dual;
                  r_lose_err <= w_dual_wr ? E_DWRITE : E_DHOLD;
                  if (w_inuse || w_hold || w_rel) begin
                     r_state <= S_RESP;
                     A_done  <= ~w_win_b | w_dual;
                     B_done  <= w_win_b | w_dual;
                     if (w_win_b) begin
                        B_err <= w_inuse ? E_INUSE : E_NONE;
                        A_err <= w_dual ? E_DHOLD : E_NONE;
                     end else begin
                        A_err <= w_inuse ? E_INUSE : E_NONE;
                        B_err <= w_dual ? E_DHOLD : E_NONE;
                     end
                     if (!w_inuse && w_hold) begin
                        if (w_win_b) B_locks[w_addr] <= 1'b1;
                        else         A_locks[w_addr] <= 1'b1;
                     end else if (!w_inuse && w_rel) begin
                        if (w_win_b) B_locks[w_addr] <= 1'b0;
                        else         A_locks[w_addr] <= 1'b0;
                     end
                  end else begin
                     r_state   <= S_ISSUE;
                     mem_en    <= 1'b1;
                     mem_we    <= w_rw;
                     mem_addr  <= w_addr;
                     mem_wdata <= w_wdata;
                  end
               end
            end

            S_ISSUE: begin
               mem_en <= 1'b0;
               mem_we <= 1'b0;
               if (mem_we) begin
                  r_state <= S_RESP;
                  A_done  <= ~r_win_b | r_lose_dn;
                  B_done  <= r_win_b | r_lose_dn;
                  A_err   <= (r_win_b && r_lose_dn) ? r_lose_err : E_NONE;
                  B_err   <= (!r_win_b && r_lose_dn) ? r_lose_err : E_NONE;
               end else begin
                  r_state <= S_RDATA;
               end
            end

            S_RDATA: begin
               r_state <= S_RESP;
               if (r_win_b) B_rdata <= mem_rdata;
               else         A_rdata <= mem_rdata;
               A_done <= ~r_win_b;
               B_done <= r_win_b;
               A_err  <= E_NONE;
               B_err  <= E_NONE;
            end

            S_RESP: begin
               r_state   <= S_IDLE;
               r_lose_dn <= 1'b0;
               A_done    <= 1'b0;
               B_done    <= 1'b0;
               A_err     <= E_NONE;
               B_err     <= E_NONE;
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_csm_arbiter.sv
// tb_csm_arbiter: directed scenario bench for csm_arbiter with a simple synchronous memory model.
`default_nettype none

module tb_csm_arbiter;

   logic       clk;
   logic       reset_n;
   logic       A_req, A_rw, A_hold, A_release;
   logic [2:0] A_addr;
   logic [7:0] A_wdata;
   logic       A_done;
   logic [1:0] A_err;
   logic [7:0] A_rdata;
   logic [7:0] A_locks;
   logic       B_req, B_rw, B_hold, B_release;
   logic [2:0] B_addr;
   logic [7:0] B_wdata;
   logic       B_done;
   logic [1:0] B_err;
   logic [7:0] B_rdata;
   logic [7:0] B_locks;
   logic       mem_en, mem_we;
   logic [2:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   logic [7:0] tb_mem [8];

   csm_arbiter #(.DATABITS(8), .MEMSIZE(8)) dut (
      .clk(clk), .reset_n(reset_n),
      .A_req(A_req), .A_rw(A_rw), .A_hold(A_hold), .A_release(A_release),
      .A_addr(A_addr), .A_wdata(A_wdata), .A_done(A_done), .A_err(A_err),
      .A_rdata(A_rdata), .A_locks(A_locks),
      .B_req(B_req), .B_rw(B_rw), .B_hold(B_hold), .B_release(B_release),
      .B_addr(B_addr), .B_wdata(B_wdata), .B_done(B_done), .B_err(B_err),
      .B_rdata(B_rdata), .B_locks(B_locks),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) tb_mem[mem_addr] <= mem_wdata;
         else        mem_rdata <= tb_mem[mem_addr];
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_a(input logic req, input logic rw, input logic hold,
                        input logic rel, input logic [2:0] addr, input logic [7:0] wd);
      A_req = req; A_rw = rw; A_hold = hold; A_release = rel; A_addr = addr; A_wdata = wd;
   endtask

   task automatic set_b(input logic req, input logic rw, input logic hold,
                        input logic rel, input logic [2:0] addr, input logic [7:0] wd);
      B_req = req; B_rw = rw; B_hold = hold; B_release = rel; B_addr = addr; B_wdata = wd;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      set_a(0, 0, 0, 0, 3'd0, 8'h00);
      set_b(0, 0, 0, 0, 3'd0, 8'h00);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      cyc();
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({A_done, B_done, A_err, B_err, A_rdata, B_rdata, A_locks, B_locks,
           mem_en, mem_we, mem_addr, mem_wdata} !== 55'd0) begin
         errors++;
         $display("FAIL reset_outputs got A_done=%0b B_done=%0b A_locks=%h B_locks=%h mem_en=%0b expected all zero",
                  A_done, B_done, A_locks, B_locks, mem_en);
      end
   endtask

   task automatic test_reset_mid_op();
      do_reset();
      set_a(1, 0, 1, 0, 3'd0, 8'h00);
      cyc();
      checks++;
      if ({A_done, A_locks} !== {1'b1, 8'h01}) begin
         errors++;
         $display("FAIL rst_setup_hold got done=%0b locks=%h expected 1 01", A_done, A_locks);
      end
      set_a(0, 0, 0, 0, 3'd0, 8'h00);
      cyc();
      set_a(1, 0, 0, 0, 3'd1, 8'h00);
      cyc();
      cyc();
      reset_n = 1'b0;
      set_a(0, 0, 0, 0, 3'd0, 8'h00);
      #1;
      checks++;
      if ({A_done, B_done, A_err, B_err, A_locks, B_locks, mem_en, mem_we, mem_addr} !== 26'd0) begin
         errors++;
         $display("FAIL rst_mid_read got A_done=%0b A_locks=%h mem_en=%0b mem_addr=%0d expected all zero",
                  A_done, A_locks, mem_en, mem_addr);
      end
      cyc();
      cyc();
      checks++;
      if ({A_done, B_done} !== 2'b00) begin
         errors++;
         $display("FAIL rst_no_done got A_done=%0b B_done=%0b expected 0 0", A_done, B_done);
      end
      reset_n = 1'b1;
      cyc();
      // read in flight during ISSUE: mem_en must fall without a clock edge
      set_a(1, 0, 0, 0, 3'd6, 8'h00);
      cyc();
      reset_n = 1'b0;
      set_a(0, 0, 0, 0, 3'd0, 8'h00);
      #1;
      checks++;
      if (mem_en !== 1'b0) begin
         errors++;
         $display("FAIL rst_async_mem_en got %0b expected 0", mem_en);
      end
      cyc();
      reset_n = 1'b1;
      cyc();
      set_a(1, 1, 0, 0, 3'd4, 8'h3C);
      cyc();
      checks++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 3'd4, 8'h3C}) begin
         errors++;
         $display("FAIL rst_after_issue got en=%0b we=%0b addr=%0d wdata=%h expected 1 1 4 3c",
                  mem_en, mem_we, mem_addr, mem_wdata);
      end
      cyc();
      checks++;
      if ({A_done, A_err} !== {1'b1, 2'b00}) begin
         errors++;
         $display("FAIL rst_after_done got done=%0b err=%b expected 1 00", A_done, A_err);
      end
      set_a(0, 0, 0, 0, 3'd0, 8'h00);
      cyc();
   endtask

   task automatic test_write_read();
      do_reset();
      set_a(1, 1, 0, 0, 3'd3, 8'h5A);
      cyc();
      checks++;
      if ({mem_en, mem_we, mem_addr, mem_wdata, A_done} !== {1'b1, 1'b1, 3'd3, 8'h5A, 1'b0}) begin
         errors++;
         $display("FAIL wr_issue got en=%0b we=%0b addr=%0d wdata=%h done=%0b expected 1 1 3 5a 0",
                  mem_en, mem_we, mem_addr, mem_wdata, A_done);
      end
      cyc();
      checks++;
      if ({A_done, A_err, mem_en} !== {1'b1, 2'b00, 1'b0}) begin
         errors++;
         $display("FAIL wr_done got done=%0b err=%b en=%0b expected 1 00 0", A_done, A_err, mem_en);
      end
      set_a(0, 0, 0, 0, 3'd0, 8'h00);
      cyc();
      set_a(1, 0, 0, 0, 3'd3, 8'h00);
      cyc();
      checks++;
      if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 3'd3}) begin
         errors++;
         $display("FAIL rd_issue got en=%0b we=%0b addr=%0d expected 1 0 3", mem_en, mem_we, mem_addr);
      end
      cyc();
      checks++;
      if (A_done !== 1'b0) begin
         errors++;
         $display("FAIL rd_no_early_done got %0b expected 0", A_done);
      end
      cyc();
      checks++;
      if ({A_done, A_err, A_rdata} !== {1'b1, 2'b00, 8'h5A}) begin
         errors++;
         $display("FAIL rd_done got done=%0b err=%b rdata=%h expected 1 00 5a", A_done, A_err, A_rdata);
      end
      set_a(0, 0, 0, 0, 3'd0, 8'h00);
      cyc();
      checks++;
      if ({A_done, A_err, A_rdata} !== {1'b0, 2'b00, 8'h5A}) begin
         errors++;
         $display("FAIL rd_hold got done=%0b err=%b rdata=%h expected 0 00 5a", A_done, A_err, A_rdata);
      end
   endtask

   task automatic test_lock_protection();
      do_reset();
      set_a(1, 0, 1, 0, 3'd2, 8'h00);
      cyc();
      checks++;
      if ({A_done, A_err, A_locks, mem_en} !== {1'b1, 2'b00, 8'h04, 1'b0}) begin
         errors++;
         $display("FAIL lock_hold got done=%0b err=%b locks=%h en=%0b expected 1 00 04 0",
                  A_done, A_err, A_locks, mem_en);
      end
      set_a(0, 0, 0, 0, 3'd0, 8'h00);
      cyc();
      set_b(1, 1, 0, 0, 3'd2, 8'h77);
      cyc();
      checks++;
      if ({B_done, B_err, mem_en, A_done} !== {1'b1, 2'b01, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL lock_inuse got done=%0b err=%b en=%0b A_done=%0b expected 1 01 0 0",
                  B_done, B_err, mem_en, A_done);
      end
      set_b(0, 0, 0, 0, 3'd0, 8'h00);
      cyc();
      set_a(1, 0, 0, 1, 3'd2, 8'h00);
      cyc();
      checks++;
      if ({A_done, A_err, A_locks} !== {1'b1, 2'b00, 8'h00}) begin
         errors++;
         $display("FAIL lock_release got done=%0b err=%b locks=%h expected 1 00 00", A_done, A_err, A_locks);
      end
      set_a(0, 0, 0, 0, 3'd0, 8'h00);
      cyc();
      set_b(1, 1, 0, 0, 3'd2, 8'h77);
      cyc();
      checks++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 3'd2, 8'h77}) begin
         errors++;
         $display("FAIL lock_retry_issue got en=%0b we=%0b addr=%0d wdata=%h expected 1 1 2 77",
                  mem_en, mem_we, mem_addr, mem_wdata);
      end
      cyc();
      checks++;
      if ({B_done, B_err} !== {1'b1, 2'b00}) begin
         errors++;
         $display("FAIL lock_retry_done got done=%0b err=%b expected 1 00", B_done, B_err);
      end
      set_b(0, 0, 0, 0, 3'd0, 8'h00);
      cyc();
   endtask

   task automatic test_dual_write();
      do_reset();
      set_a(1, 1, 0, 0, 3'd5, 8'h11);
      set_b(1, 1, 0, 0, 3'd5, 8'h22);
      cyc();
      checks++;
      if ({mem_en, mem_we, mem_addr, mem_wdata, A_done, B_done} !== {1'b1, 1'b1, 3'd5, 8'h11, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL dw_issue got en=%0b addr=%0d wdata=%h A_done=%0b B_done=%0b expected 1 5 11 0 0",
                  mem_en, mem_addr, mem_wdata, A_done, B_done);
      end
      cyc();
      checks++;
      if ({A_done, A_err, B_done, B_err, mem_en} !== {1'b1, 2'b00, 1'b1, 2'b10, 1'b0}) begin
         errors++;
         $display("FAIL dw_done got A=%0b/%b B=%0b/%b en=%0b expected 1/00 1/10 0",
                  A_done, A_err, B_done, B_err, mem_en);
      end
      set_a(0, 0, 0, 0, 3'd0, 8'h00);
      set_b(0, 0, 0, 0, 3'd0, 8'h00);
      cyc();
      checks++;
      if (mem_en !== 1'b0) begin
         errors++;
         $display("FAIL dw_no_second_write got en=%0b expected 0", mem_en);
      end
      // A won last, so B must win the next contested arbitration
      set_a(1, 0, 0, 0, 3'd1, 8'h00);
      set_b(1, 0, 0, 0, 3'd5, 8'h00);
      cyc();
      checks++;
      if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 3'd5}) begin
         errors++;
         $display("FAIL dw_lastwin_grant got en=%0b we=%0b addr=%0d expected 1 0 5", mem_en, mem_we, mem_addr);
      end
      cyc();
      cyc();
      checks++;
      if ({B_done, B_err, B_rdata, A_done} !== {1'b1, 2'b00, 8'h11, 1'b0}) begin
         errors++;
         $display("FAIL dw_readback got B_done=%0b err=%b rdata=%h A_done=%0b expected 1 00 11 0",
                  B_done, B_err, B_rdata, A_done);
      end
      set_b(0, 0, 0, 0, 3'd0, 8'h00);
      cyc();
      cyc();
      checks++;
      if ({mem_en, mem_addr} !== {1'b1, 3'd1}) begin
         errors++;
         $display("FAIL dw_pending_a got en=%0b addr=%0d expected 1 1", mem_en, mem_addr);
      end
      cyc();
      cyc();
      set_a(0, 0, 0, 0, 3'd0, 8'h00);
      cyc();
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int r = 0; r < 2; r++) begin
         set_a(1, 0, 0, 0, 3'd1, 8'h00);
         set_b(1, 0, 0, 0, 3'd2, 8'h00);
         cyc();
         checks++;
         if ({mem_en, mem_addr} !== {1'b1, 3'd1}) begin
            errors++;
            $display("FAIL rr_first_%0d got en=%0b addr=%0d expected 1 1", r, mem_en, mem_addr);
         end
         cyc();
         cyc();
         checks++;
         if ({A_done, B_done} !== 2'b10) begin
            errors++;
            $display("FAIL rr_first_done_%0d got A=%0b B=%0b expected 1 0", r, A_done, B_done);
         end
         set_a(0, 0, 0, 0, 3'd0, 8'h00);
         cyc();
         cyc();
         checks++;
         if ({mem_en, mem_addr} !== {1'b1, 3'd2}) begin
            errors++;
            $display("FAIL rr_second_%0d got en=%0b addr=%0d expected 1 2", r, mem_en, mem_addr);
         end
         cyc();
         cyc();
         checks++;
         if ({A_done, B_done} !== 2'b01) begin
            errors++;
            $display("FAIL rr_second_done_%0d got A=%0b B=%0b expected 0 1", r, A_done, B_done);
         end
         set_b(0, 0, 0, 0, 3'd0, 8'h00);
         cyc();
      end
   endtask

   task automatic test_dual_hold();
      do_reset();
      set_a(1, 1, 0, 0, 3'd0, 8'hAB);
      cyc();
      cyc();
      set_a(0, 0, 0, 0, 3'd0, 8'h00);
      cyc();
      set_a(1, 0, 1, 0, 3'd7, 8'h00);
      set_b(1, 0, 1, 0, 3'd7, 8'h00);
      cyc();
      checks++;
      if ({A_done, A_err, B_done, B_err} !== {1'b1, 2'b11, 1'b1, 2'b00}) begin
         errors++;
         $display("FAIL dh_done got A=%0b/%b B=%0b/%b expected 1/11 1/00", A_done, A_err, B_done, B_err);
      end
      checks++;
      if ({A_locks, B_locks, mem_en} !== {8'h00, 8'h80, 1'b0}) begin
         errors++;
         $display("FAIL dh_locks got A_locks=%h B_locks=%h en=%0b expected 00 80 0", A_locks, B_locks, mem_en);
      end
      set_a(0, 0, 0, 0, 3'd0, 8'h00);
      set_b(0, 0, 0, 0, 3'd0, 8'h00);
      cyc();
      checks++;
      if ({A_done, A_err, B_done, B_err, B_locks} !== {1'b0, 2'b00, 1'b0, 2'b00, 8'h80}) begin
         errors++;
         $display("FAIL dh_after got A=%0b/%b B=%0b/%b B_locks=%h expected 0/00 0/00 80",
                  A_done, A_err, B_done, B_err, B_locks);
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) tb_mem[i] = 8'h00;
      mem_rdata = 8'h00;
      reset_n   = 1'b0;
      set_a(0, 0, 0, 0, 3'd0, 8'h00);
      set_b(0, 0, 0, 0, 3'd0, 8'h00);
      test_reset();
      test_reset_mid_op();
      test_write_read();
      test_lock_protection();
      test_dual_write();
      test_round_robin();
      test_dual_hold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
